// File: rtl/tbird_seq_lights_if.sv
// Control/lamp bundle between the driver-control block and the tail-light controller.
//   left, right, haz, brake : debounced driver requests (driven by master)
//   l_lights, r_lights      : lamp drives, bit 0 innermost (driven by slave)
//   busy                    : controller is not idle (driven by slave)
interface tbird_seq_lights_if #(
    parameter int unsigned N_LAMPS = 3
) ();
    logic               left;
    logic               right;
    logic               haz;
    logic               brake;
    logic [N_LAMPS-1:0] l_lights;
    logic [N_LAMPS-1:0] r_lights;
    logic               busy;

    modport master (
        output left, right, haz, brake,
        input  l_lights, r_lights, busy
    );

    modport slave (
        input  left, right, haz, brake,
        output l_lights, r_lights, busy
    );
endinterface

// File: rtl/tbird_seq_lights.sv
// Sequential tail-light controller: N_LAMPS lamps per side, TICK_DIV cycles per
// animation step, hazard abort at step boundaries and a combinational brake overlay.
//   clk   : clock, rising edge
//   rst_b : asynchronous active-low reset
//   bus   : slave side of tbird_seq_lights_if (requests in, lamps/busy out)
module tbird_seq_lights #(
    parameter int unsigned N_LAMPS  = 3,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic               clk,
    input  logic               rst_b,
    tbird_seq_lights_if.slave  bus
);

    localparam int unsigned KW = $clog2(N_LAMPS + 1);
    localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2,
        ST_HAZ   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [DW-1:0]   d_q, d_d;
    logic            boundary;
    logic [N_LAMPS-1:0] base_l, base_r;

    // State, step counter and divider registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            d_q     <= d_d;
        end
    end

    // Next-state logic; request inputs only matter in IDLE or at a step boundary
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        d_d      = d_q;
        boundary = (d_q == DW'(TICK_DIV - 1));

        case (state_q)
            ST_IDLE: begin
                if ((bus.left && bus.right) || bus.haz) begin
                    state_d = ST_HAZ;
                    k_d     = '0;
                end else if (bus.left) begin
                    state_d = ST_LEFT;
                    k_d     = KW'(1);
                end else if (bus.right) begin
                    state_d = ST_RIGHT;
                    k_d     = KW'(1);
                end
            end
            ST_LEFT, ST_RIGHT: begin
                if (boundary) begin
                    // The last step always completes; haz is only honoured before it
                    if (k_q == KW'(N_LAMPS)) begin
                        state_d = ST_IDLE;
                        k_d     = '0;
                    end else if (bus.haz) begin
                        state_d = ST_HAZ;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            ST_HAZ: begin
                if (boundary) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                k_d     = '0;
            end
        endcase

        // Divider free-runs while active, parked at zero in IDLE
        if (state_q == ST_IDLE) begin
            d_d = '0;
        end else begin
            d_d = boundary ? '0 : d_q + DW'(1);
        end
    end

    // Base lamp decode: k lowest lamps lit on the sequencing side
    always_comb begin
        base_l = '0;
        base_r = '0;
        for (int i = 0; i < N_LAMPS; i++) begin
            if (KW'(i) < k_q) begin
                if (state_q == ST_LEFT)  base_l[i] = 1'b1;
                if (state_q == ST_RIGHT) base_r[i] = 1'b1;
            end
        end
        if (state_q == ST_HAZ) begin
            base_l = '1;
            base_r = '1;
        end
    end

    // Brake lights every side that is not currently sequencing
    always_comb begin
        bus.l_lights = base_l;
        bus.r_lights = base_r;
        if (bus.brake) begin
            if (state_q != ST_LEFT)  bus.l_lights = '1;
            if (state_q != ST_RIGHT) bus.r_lights = '1;
        end
        bus.busy = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_tbird_seq_lights.sv
// Self-checking bench for tbird_seq_lights: directed scenarios on a 4-lamp/2-cycle
// instance and a 3-lamp/1-cycle instance, plus randomized traffic checked against
// a frame-schedule reference model.
module tb_tbird_seq_lights;

    localparam int unsigned NA = 4;
    localparam int unsigned TA = 2;
    localparam int unsigned NB = 3;
    localparam int unsigned TB = 1;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    tbird_seq_lights_if #(.N_LAMPS(NA)) bus_a ();
    tbird_seq_lights_if #(.N_LAMPS(NB)) bus_b ();

    tbird_seq_lights #(.N_LAMPS(NA), .TICK_DIV(TA)) dut_a (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus_a.slave)
    );

    tbird_seq_lights #(.N_LAMPS(NB), .TICK_DIV(TB)) dut_b (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus_b.slave)
    );

    int pass_cnt  = 0;
    int check_cnt = 0;

    localparam logic [NA-1:0] ONES_A = '1;

    // Reference model: queue of future output frames (one per clock cycle)
    typedef struct {
        int kind;      // 0 left, 1 right, 2 hazard
        int lvl;       // lamps lit on sequencing side
        bit end_step;  // last cycle of its step
    } frame_t;

    frame_t mq[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic l, input logic r, input logic h, input logic b);
        bus_a.left  = l;
        bus_a.right = r;
        bus_a.haz   = h;
        bus_a.brake = b;
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        set_a(0, 0, 0, 0);
        bus_b.left = 0; bus_b.right = 0; bus_b.haz = 0; bus_b.brake = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        cyc();
    endtask

    function automatic logic [NA-1:0] seq_a(input int lvl);
        return NA'((1 << lvl) - 1);
    endfunction

    task automatic test_reset();
        rst_b = 1'b0;
        set_a(0, 0, 0, 0);
        bus_b.left = 0; bus_b.right = 0; bus_b.haz = 0; bus_b.brake = 0;
        #2;
        check_cnt++;
        if ({bus_a.l_lights, bus_a.r_lights, bus_a.busy} !== {2*NA+1{1'b0}})
            $display("FAIL reset_a got l=%b r=%b busy=%b exp all 0", bus_a.l_lights, bus_a.r_lights, bus_a.busy);
        else pass_cnt++;
        check_cnt++;
        if ({bus_b.l_lights, bus_b.r_lights, bus_b.busy} !== {2*NB+1{1'b0}})
            $display("FAIL reset_b got l=%b r=%b busy=%b exp all 0", bus_b.l_lights, bus_b.r_lights, bus_b.busy);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        cyc();
        @(negedge clk);
        check_cnt++;
        if ({bus_a.l_lights, bus_a.r_lights, bus_a.busy} !== {2*NA+1{1'b0}})
            $display("FAIL post_reset_a got l=%b r=%b busy=%b exp all 0", bus_a.l_lights, bus_a.r_lights, bus_a.busy);
        else pass_cnt++;
        cyc();
    endtask

    task automatic test_left();
        set_a(1, 0, 0, 0);
        cyc();
        set_a(0, 0, 0, 0);
        for (int i = 0; i < int'(NA * TA); i++) begin
            @(negedge clk);
            check_cnt++;
            if ({bus_a.l_lights, bus_a.r_lights, bus_a.busy} !== {seq_a(i / TA + 1), {NA{1'b0}}, 1'b1})
                $display("FAIL left_seq cyc=%0d got l=%b r=%b busy=%b exp l=%b r=0 busy=1",
                         i, bus_a.l_lights, bus_a.r_lights, bus_a.busy, seq_a(i / TA + 1));
            else pass_cnt++;
            cyc();
        end
        @(negedge clk);
        check_cnt++;
        if ({bus_a.l_lights, bus_a.r_lights, bus_a.busy} !== {2*NA+1{1'b0}})
            $display("FAIL left_end got l=%b r=%b busy=%b exp all 0", bus_a.l_lights, bus_a.r_lights, bus_a.busy);
        else pass_cnt++;
        cyc();
    endtask

    task automatic test_haz_abort();
        logic [NA-1:0] exp_v;
        set_a(0, 1, 0, 0);
        repeat (4) cyc();
        set_a(0, 1, 1, 0);
        @(negedge clk);
        check_cnt++;
        if (bus_a.r_lights !== seq_a(2))
            $display("FAIL haz_pre got r=%b exp %b", bus_a.r_lights, seq_a(2));
        else pass_cnt++;
        cyc();
        for (int j = 0; j < 6; j++) begin
            exp_v = ((j % 3) == 2) ? '0 : ONES_A;
            @(negedge clk);
            check_cnt++;
            if ({bus_a.l_lights, bus_a.r_lights, bus_a.busy} !== {exp_v, exp_v, (j % 3) != 2})
                $display("FAIL haz_flash cyc=%0d got l=%b r=%b busy=%b exp l=r=%b",
                         j, bus_a.l_lights, bus_a.r_lights, bus_a.busy, exp_v);
            else pass_cnt++;
            cyc();
        end
        set_a(0, 0, 0, 0);
        repeat (2) cyc();
        @(negedge clk);
        check_cnt++;
        if ({bus_a.l_lights, bus_a.r_lights, bus_a.busy} !== {2*NA+1{1'b0}})
            $display("FAIL haz_end got l=%b r=%b busy=%b exp all 0", bus_a.l_lights, bus_a.r_lights, bus_a.busy);
        else pass_cnt++;
        cyc();

        // haz during the final step must not divert into HAZ
        set_a(0, 1, 0, 0);
        cyc();
        set_a(0, 0, 0, 0);
        repeat (6) cyc();
        set_a(0, 0, 1, 0);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check_cnt++;
            if ({bus_a.l_lights, bus_a.r_lights} !== {{NA{1'b0}}, ONES_A})
                $display("FAIL haz_last_step cyc=%0d got l=%b r=%b exp l=0 r=%b", j, bus_a.l_lights, bus_a.r_lights, ONES_A);
            else pass_cnt++;
            cyc();
        end
        set_a(0, 0, 0, 0);
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            check_cnt++;
            if ({bus_a.l_lights, bus_a.r_lights, bus_a.busy} !== {2*NA+1{1'b0}})
                $display("FAIL haz_last_idle cyc=%0d got l=%b r=%b busy=%b exp all 0",
                         j, bus_a.l_lights, bus_a.r_lights, bus_a.busy);
            else pass_cnt++;
            cyc();
        end
    endtask

    task automatic test_simultaneous();
        logic [2*NA:0] exp_v;
        set_a(1, 1, 0, 0);
        cyc();
        set_a(0, 0, 0, 0);
        for (int j = 0; j < 4; j++) begin
            exp_v = (j < int'(TA)) ? {ONES_A, ONES_A, 1'b1} : '0;
            @(negedge clk);
            check_cnt++;
            if ({bus_a.l_lights, bus_a.r_lights, bus_a.busy} !== exp_v)
                $display("FAIL simul cyc=%0d got %b exp %b", j, {bus_a.l_lights, bus_a.r_lights, bus_a.busy}, exp_v);
            else pass_cnt++;
            cyc();
        end
    endtask

    task automatic test_brake();
        set_a(0, 0, 0, 1);
        #1;
        check_cnt++;
        if ({bus_a.l_lights, bus_a.r_lights, bus_a.busy} !== {ONES_A, ONES_A, 1'b0})
            $display("FAIL brake_idle got l=%b r=%b busy=%b exp l=r=%b busy=0",
                     bus_a.l_lights, bus_a.r_lights, bus_a.busy, ONES_A);
        else pass_cnt++;
        set_a(0, 1, 0, 1);
        cyc();
        set_a(0, 0, 0, 1);
        for (int i = 0; i < int'(NA * TA); i++) begin
            @(negedge clk);
            check_cnt++;
            if ({bus_a.l_lights, bus_a.r_lights, bus_a.busy} !== {ONES_A, seq_a(i / TA + 1), 1'b1})
                $display("FAIL brake_right cyc=%0d got l=%b r=%b busy=%b exp l=%b r=%b",
                         i, bus_a.l_lights, bus_a.r_lights, bus_a.busy, ONES_A, seq_a(i / TA + 1));
            else pass_cnt++;
            cyc();
        end
        set_a(0, 0, 0, 0);
        #1;
        check_cnt++;
        if ({bus_a.l_lights, bus_a.r_lights, bus_a.busy} !== {2*NA+1{1'b0}})
            $display("FAIL brake_release got l=%b r=%b busy=%b exp all 0", bus_a.l_lights, bus_a.r_lights, bus_a.busy);
        else pass_cnt++;
        cyc();
    endtask

    task automatic test_compat();
        logic [NB-1:0] pat [4];
        pat[0] = 3'b001; pat[1] = 3'b011; pat[2] = 3'b111; pat[3] = 3'b000;
        bus_b.left = 1;
        cyc();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_cnt++;
            if ({bus_b.l_lights, bus_b.r_lights} !== {pat[i % 4], {NB{1'b0}}})
                $display("FAIL compat cyc=%0d got l=%b r=%b exp l=%b r=000", i, bus_b.l_lights, bus_b.r_lights, pat[i % 4]);
            else pass_cnt++;
            if (i == 7) bus_b.left = 0;
            cyc();
        end
        @(negedge clk);
        check_cnt++;
        if (bus_b.busy !== 1'b0)
            $display("FAIL compat_end got busy=%b exp 0", bus_b.busy);
        else pass_cnt++;
        cyc();
    endtask

    task automatic test_reset_mid();
        set_a(1, 0, 0, 0);
        cyc();
        set_a(0, 0, 0, 0);
        repeat (2) cyc();
        #2;
        rst_b = 1'b0;
        #1;
        check_cnt++;
        if ({bus_a.l_lights, bus_a.r_lights, bus_a.busy} !== {2*NA+1{1'b0}})
            $display("FAIL reset_mid got l=%b r=%b busy=%b exp all 0", bus_a.l_lights, bus_a.r_lights, bus_a.busy);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        for (int j = 0; j < 3; j++) begin
            cyc();
            @(negedge clk);
            check_cnt++;
            if ({bus_a.l_lights, bus_a.r_lights, bus_a.busy} !== {2*NA+1{1'b0}})
                $display("FAIL reset_mid_idle cyc=%0d got l=%b r=%b busy=%b exp all 0",
                         j, bus_a.l_lights, bus_a.r_lights, bus_a.busy);
            else pass_cnt++;
        end
        cyc();
    endtask

    task automatic push_seq(input int kind);
        for (int s = 1; s <= int'(NA); s++)
            for (int c = 0; c < int'(TA); c++)
                mq.push_back('{kind: kind, lvl: s, end_step: (c == int'(TA) - 1)});
    endtask

    task automatic push_haz();
        for (int c = 0; c < int'(TA); c++)
            mq.push_back('{kind: 2, lvl: int'(NA), end_step: (c == int'(TA) - 1)});
    endtask

    // Advance the model by one clock edge given the inputs sampled at that edge
    task automatic model_step(input logic l, input logic r, input logic h);
        frame_t f;
        if (mq.size() == 0) begin
            if ((l && r) || h) push_haz();
            else if (l)        push_seq(0);
            else if (r)        push_seq(1);
        end else begin
            f = mq.pop_front();
            if (f.end_step && f.kind != 2 && f.lvl != int'(NA) && h) begin
                mq.delete();
                push_haz();
            end
        end
    endtask

    task automatic test_random();
        logic [NA-1:0] el, er;
        logic eb;
        logic l, r, h, b;
        do_reset();
        mq.delete();
        for (int n = 0; n < 600; n++) begin
            l = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 7) == 0);
            h = ($urandom_range(0, 15) == 0);
            b = ($urandom_range(0, 3) == 0);
            set_a(l, r, h, b);
            el = '0; er = '0; eb = (mq.size() != 0);
            if (eb) begin
                if (mq[0].kind == 0) el = seq_a(mq[0].lvl);
                else if (mq[0].kind == 1) er = seq_a(mq[0].lvl);
                else begin el = ONES_A; er = ONES_A; end
            end
            if (b) begin
                if (!eb || mq[0].kind != 0) el = ONES_A;
                if (!eb || mq[0].kind != 1) er = ONES_A;
            end
            @(negedge clk);
            check_cnt++;
            if ({bus_a.l_lights, bus_a.r_lights, bus_a.busy} !== {el, er, eb})
                $display("FAIL random cyc=%0d got l=%b r=%b busy=%b exp l=%b r=%b busy=%b",
                         n, bus_a.l_lights, bus_a.r_lights, bus_a.busy, el, er, eb);
            else pass_cnt++;
            cyc();
            model_step(l, r, h);
        end
        set_a(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_left();
        test_haz_abort();
        test_simultaneous();
        test_brake();
        test_compat();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
